vga_rect_fill: RTL and testbench

//  Hardware rectangle draw engine; the writer side of the 80x60 framebuffer port (WA/WD/WE).
//  The RAT MCU loads corners and a colour, pulses START, and the engine writes one pixel per CLK.
//  The MCU's own framebuffer writes are muxed in with priority; the engine stalls on collision.

---
 rtl/vga_rect_fill.sv | 147 ++++++++++++++
 tb/tb_vga_rect_fill.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill.sv
// Rectangle draw engine feeding the framebuffer write port; writes one pixel per clock.
// Latency: START -> first pixel on the next cycle; DONE one cycle after the last pixel.
// Backpressure: an MCU write (mcu_we_i) takes the port and the engine holds its pixel for retry.
module vga_rect_fill #(
    parameter int H_PIX = 80,
    parameter int V_PIX = 60
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  x0_i,
    input  logic [5:0]  y0_i,
    input  logic [6:0]  x1_i,
    input  logic [5:0]  y1_i,
    input  logic [7:0]  color_i,
    input  logic        outline_i,
    input  logic        start_i,
    input  logic [12:0] mcu_wa_i,
    input  logic [7:0]  mcu_wd_i,
    input  logic        mcu_we_i,
    output logic [12:0] wa_o,
    output logic [7:0]  wd_o,
    output logic        we_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [6:0] X_MAX = 7'(H_PIX - 1);
    localparam logic [5:0] Y_MAX = 6'(V_PIX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cx_q, cx_d;
    logic [5:0]  cy_q, cy_d;
    logic [6:0]  x0_q, x0_d;
    logic [5:0]  y0_q, y0_d;
    logic [6:0]  xe_q, xe_d;
    logic [5:0]  ye_q, ye_d;
    logic [7:0]  color_q, color_d;
    logic        outline_q, outline_d;

    logic [6:0]  xe_in;
    logic [5:0]  ye_in;
    logic        border;

    // Clip the far corner to the visible area before it is latched.
    always_comb begin
        xe_in = (x1_i > X_MAX) ? X_MAX : x1_i;
        ye_in = (y1_i > Y_MAX) ? Y_MAX : y1_i;
    end

    // State and command registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            xe_q      <= '0;
            ye_q      <= '0;
            color_q   <= '0;
            outline_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            xe_q      <= xe_d;
            ye_q      <= ye_d;
            color_q   <= color_d;
            outline_q <= outline_d;
        end
    end

    // Next state: accept a command in IDLE, raster-scan in RUN, pulse DONE in FIN.
    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        xe_d      = xe_q;
        ye_d      = ye_q;
        color_d   = color_q;
        outline_d = outline_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x0_d      = x0_i;
                    y0_d      = y0_i;
                    xe_d      = xe_in;
                    ye_d      = ye_in;
                    color_d   = color_i;
                    outline_d = outline_i;
                    // An off-screen or inverted corner pair draws nothing.
                    if ((x0_i > xe_in) || (y0_i > ye_in)) begin
                        state_d = FIN;
                    end else begin
                        cx_d    = x0_i;
                        cy_d    = y0_i;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // The counters only move when the pixel actually got the port.
                if (!mcu_we_i) begin
                    if (cx_q == xe_q) begin
                        cx_d = x0_q;
                        if (cy_q == ye_q) begin
                            state_d = FIN;
                        end else begin
                            cy_d = cy_q + 6'd1;
                        end
                    end else begin
                        cx_d = cx_q + 7'd1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write-port mux: MCU first, then the engine; outline mode masks interior pixels.
    always_comb begin
        border = (cx_q == x0_q) || (cx_q == xe_q) || (cy_q == y0_q) || (cy_q == ye_q);
        wa_o   = mcu_wa_i;
        wd_o   = mcu_wd_i;
        we_o   = mcu_we_i;
        if (!mcu_we_i && !rst_i && (state_q == RUN)) begin
            wa_o = {cy_q, cx_q};
            wd_o = color_q;
            we_o = !outline_q || border;
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == FIN);

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: directed scenarios plus randomized commands
// checked against a raster-order pixel list built from the corner rules.
module tb_vga_rect_fill;

    localparam int H = 80;
    localparam int V = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  x0, x1;
    logic [5:0]  y0, y1;
    logic [7:0]  color;
    logic        outline;
    logic        start;
    logic [12:0] mcu_wa;
    logic [7:0]  mcu_wd;
    logic        mcu_we;
    logic [12:0] wa;
    logic [7:0]  wd;
    logic        we;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    // {we, wa} per visited pixel in raster order
    logic [13:0] pix_q[$];

    vga_rect_fill #(.H_PIX(H), .V_PIX(V)) dut (
        .clk_i(clk), .rst_i(rst),
        .x0_i(x0), .y0_i(y0), .x1_i(x1), .y1_i(y1),
        .color_i(color), .outline_i(outline), .start_i(start),
        .mcu_wa_i(mcu_wa), .mcu_wd_i(mcu_wd), .mcu_we_i(mcu_we),
        .wa_o(wa), .wd_o(wd), .we_o(we), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Reference: every visible pixel of the clipped rectangle, row by row.
    function automatic void build_model(input int ax0, ay0, ax1, ay1, input bit ol);
        int xe, ye;
        pix_q.delete();
        xe = (ax1 > H - 1) ? H - 1 : ax1;
        ye = (ay1 > V - 1) ? V - 1 : ay1;
        for (int r = ay0; r <= ye; r++) begin
            for (int c = ax0; c <= xe; c++) begin
                bit edge_px;
                edge_px = (c == ax0) || (c == xe) || (r == ay0) || (r == ye);
                pix_q.push_back({(!ol || edge_px), 13'(r * 128 + c)});
            end
        end
    endfunction

    // Cycle 0: present command with START; returns at the start of cycle 1 with inputs scrambled.
    task automatic start_cmd(input int ax0, ay0, ax1, ay1, input logic [7:0] col, input bit ol);
        x0 = 7'(ax0); y0 = 6'(ay0); x1 = 7'(ax1); y1 = 6'(ay1);
        color = col; outline = ol; start = 1'b1; mcu_we = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = 7'($urandom); y0 = 6'($urandom); x1 = 7'($urandom); y1 = 6'($urandom);
        color = 8'($urandom); outline = 1'($urandom);
    endtask

    task automatic test_reset();
        logic [23:0] obs, want;
        rst = 1'b1; start = 1'b0; outline = 1'b0; color = 8'h00;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        mcu_we = 1'b1; mcu_wa = 13'h1234; mcu_wd = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {we, wa, wd, busy, done}; want = {1'b1, 13'h1234, 8'hA5, 2'b00};
        n_chk++;
        if (obs !== want) begin n_fail++; $display("FAIL reset_pass_we1: got %h required %h", obs, want); end
        mcu_we = 1'b0; mcu_wa = 13'h0ABC; mcu_wd = 8'h3C;
        @(negedge clk);
        obs = {we, wa, wd, busy, done}; want = {1'b0, 13'h0ABC, 8'h3C, 2'b00};
        n_chk++;
        if (obs !== want) begin n_fail++; $display("FAIL reset_pass_we0: got %h required %h", obs, want); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [12:0] tbl [6] = '{13'h182, 13'h183, 13'h184, 13'h202, 13'h203, 13'h204};
        logic [23:0] obs, want;
        start_cmd(2, 3, 4, 4, 8'hE0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            want = (c <= 6) ? {1'b1, tbl[c-1], 8'hE0, 2'b10} : {1'b0, mcu_wa, mcu_wd, 2'b01};
            obs  = {we, wa, wd, busy, done};
            n_chk++;
            if (obs !== want) begin n_fail++; $display("FAIL fill c%0d: got %h required %h", c, obs, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_outline();
        logic [23:0] obs, want;
        logic [12:0] pa;
        start_cmd(0, 0, 2, 2, 8'h1C, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            pa = 13'(((c - 1) / 3) * 128 + (c - 1) % 3);
            want = (c <= 9) ? {(c != 5), pa, 8'h1C, 2'b10} : {1'b0, mcu_wa, mcu_wd, 2'b01};
            obs  = {we, wa, wd, busy, done};
            n_chk++;
            if (obs !== want) begin n_fail++; $display("FAIL outline c%0d: got %h required %h", c, obs, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clip();
        logic [23:0] obs, want;
        start_cmd(78, 59, 127, 63, 8'h03, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            case (c)
                1:       want = {1'b1, 13'h1DCE, 8'h03, 2'b10};
                2:       want = {1'b1, 13'h1DCF, 8'h03, 2'b10};
                3:       want = {1'b0, mcu_wa, mcu_wd, 2'b01};
                default: want = {1'b0, mcu_wa, mcu_wd, 2'b00};
            endcase
            obs = {we, wa, wd, busy, done};
            n_chk++;
            if (obs !== want) begin n_fail++; $display("FAIL clip c%0d: got %h required %h", c, obs, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [12:0] tbl [6] = '{13'h182, 13'h183, 13'h184, 13'h202, 13'h203, 13'h204};
        logic [23:0] obs, want;
        start_cmd(2, 3, 4, 4, 8'hE0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            mcu_we = (c == 2); mcu_wa = 13'h0555; mcu_wd = 8'h5A;
            @(negedge clk);
            if (c == 1)      want = {1'b1, tbl[0], 8'hE0, 2'b10};
            else if (c == 2) want = {1'b1, 13'h0555, 8'h5A, 2'b10};
            else if (c <= 7) want = {1'b1, tbl[c-2], 8'hE0, 2'b10};
            else             want = {1'b0, 13'h0555, 8'h5A, 2'b01};
            obs = {we, wa, wd, busy, done};
            n_chk++;
            if (obs !== want) begin n_fail++; $display("FAIL stall c%0d: got %h required %h", c, obs, want); end
            @(posedge clk); #1;
        end
        mcu_we = 1'b0;
    endtask

    task automatic test_empty();
        logic [23:0] obs, want;
        start_cmd(5, 0, 4, 10, 8'hFF, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            mcu_we = 1'($urandom); mcu_wa = 13'($urandom); mcu_wd = 8'($urandom);
            @(negedge clk);
            want = {mcu_we, mcu_wa, mcu_wd, 1'b0, (c == 1)};
            obs  = {we, wa, wd, busy, done};
            n_chk++;
            if (obs !== want) begin n_fail++; $display("FAIL empty c%0d: got %h required %h", c, obs, want); end
            @(posedge clk); #1;
        end
        mcu_we = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [12:0] tbl [6] = '{13'h182, 13'h183, 13'h184, 13'h202, 13'h203, 13'h204};
        logic [23:0] obs, want;
        start_cmd(2, 3, 4, 4, 8'hE0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            start = (c == 2) || (c == 7);
            x0 = 7'd0; y0 = 6'd0; x1 = 7'd79; y1 = 6'd59; color = 8'h11; outline = 1'b0;
            @(negedge clk);
            if (c <= 6)      want = {1'b1, tbl[c-1], 8'hE0, 2'b10};
            else if (c == 7) want = {1'b0, mcu_wa, mcu_wd, 2'b01};
            else             want = {1'b0, mcu_wa, mcu_wd, 2'b00};
            obs = {we, wa, wd, busy, done};
            n_chk++;
            if (obs !== want) begin n_fail++; $display("FAIL start_ignored c%0d: got %h required %h", c, obs, want); end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [12:0] tbl [2] = '{13'h182, 13'h183};
        logic [23:0] obs, want;
        start_cmd(2, 3, 4, 4, 8'hE0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            rst = (c == 3);
            @(negedge clk);
            if (c <= 2) begin
                want = {1'b1, tbl[c-1], 8'hE0, 2'b10};
                obs  = {we, wa, wd, busy, done};
            end else if (c == 3) begin
                want = {1'b0, mcu_wa, mcu_wd, 2'b00};
                obs  = {we, wa, wd, 1'b0, done};
            end else begin
                want = {1'b0, mcu_wa, mcu_wd, 2'b00};
                obs  = {we, wa, wd, busy, done};
            end
            n_chk++;
            if (obs !== want) begin n_fail++; $display("FAIL reset_abort c%0d: got %h required %h", c, obs, want); end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [23:0] obs, want;
        logic [13:0] p;
        for (int it = 0; it < 40; it++) begin
            int ax0, ay0, ax1, ay1, cyc;
            bit ol, done_seen;
            logic [7:0] col;
            ax0 = $urandom_range(0, 84);
            ay0 = $urandom_range(0, 62);
            ax1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : ax0 + $urandom_range(0, 10);
            if (ax1 > 127) ax1 = 127;
            ay1 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 63) : ay0 + $urandom_range(0, 6);
            if (ay1 > 63) ay1 = 63;
            if (ay1 > ay0 + 6) ay1 = ay0 + 6;
            ol  = 1'($urandom);
            col = 8'($urandom);
            build_model(ax0, ay0, ax1, ay1, ol);
            start_cmd(ax0, ay0, ax1, ay1, col, ol);
            done_seen = 1'b0;
            cyc = 1;
            while (!done_seen && cyc < 5000) begin
                mcu_we = ($urandom_range(0, 3) == 0);
                mcu_wa = 13'($urandom); mcu_wd = 8'($urandom);
                @(negedge clk);
                if (pix_q.size() > 0) begin
                    if (mcu_we) begin
                        want = {1'b1, mcu_wa, mcu_wd, 2'b10};
                    end else begin
                        p = pix_q.pop_front();
                        want = {p[13], p[12:0], col, 2'b10};
                    end
                end else begin
                    want = {mcu_we, mcu_wa, mcu_wd, 2'b01};
                    done_seen = 1'b1;
                end
                obs = {we, wa, wd, busy, done};
                n_chk++;
                if (obs !== want) begin
                    n_fail++;
                    $display("FAIL random it%0d c%0d: got %h required %h", it, cyc, obs, want);
                end
                @(posedge clk); #1;
                cyc++;
            end
            if (!done_seen) begin
                n_chk++; n_fail++;
                $display("FAIL random_timeout it%0d: got no completion, required DONE", it);
            end
        end
        mcu_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_outline();
        test_clip();
        test_stall();
        test_empty();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
